// File: rtl/apb_slave_mem.sv
// apb_slave_mem: APB slave with byte-strobed word storage and programmable wait states
//   clk     - clock, rising edge
//   rst     - synchronous active-high reset
//   sel     - APB select
//   enable  - APB enable (access phase)
//   write   - 1 = write, 0 = read
//   strobe  - byte write strobes, sampled in the access phase
//   addr    - word address
//   wdata   - write data
//   rdata   - read data, non-zero only in the ready cycle of an in-range read
//   ready   - transfer complete
//   slverr  - error response for out-of-range addresses, only with ready
module apb_slave_mem #(
   parameter int ADDR_WIDTH  = 8,
   parameter int DATA_WIDTH  = 32,
   parameter int DEPTH       = 16,
   parameter int WAIT_CYCLES = 2
) (
   input  logic                    clk,
   input  logic                    rst,
   input  logic                    sel,
   input  logic                    enable,
   input  logic                    write,
   input  logic [DATA_WIDTH/8-1:0] strobe,
   input  logic [ADDR_WIDTH-1:0]   addr,
   input  logic [DATA_WIDTH-1:0]   wdata,
   output logic [DATA_WIDTH-1:0]   rdata,
   output logic                    ready,
   output logic                    slverr
);
   localparam int CW = WAIT_CYCLES > 0 ? $clog2(WAIT_CYCLES + 1) : 1;
   localparam int IW = DEPTH > 1 ? $clog2(DEPTH) : 1;
   typedef enum logic [1:0] {IDLE, ACCESS, DONE} state_t;
   state_t                  state_q, state_d;
   logic [CW-1:0]           cnt_q, cnt_d;
   logic [ADDR_WIDTH-1:0]   addr_q, addr_d;
   logic                    write_q, write_d;
   logic [DATA_WIDTH-1:0]   wdata_q, wdata_d;
   logic [DATA_WIDTH-1:0]   mem_q [DEPTH];
   logic [DATA_WIDTH-1:0]   mem_d [DEPTH];
   logic [IW-1:0]           idx;
   logic                    in_range;
   assign idx      = addr_q[IW-1:0];
   assign in_range = 32'(addr_q) < 32'(DEPTH);
   // ready is combinational in the last access cycle; gated by rst so reset forces it low
   assign ready  = ~rst & (state_q == ACCESS) & sel & enable & (cnt_q == '0);
   assign slverr = ready & ~in_range;
   assign rdata  = (ready && !write_q && in_range) ? mem_q[idx] : '0;
   always_comb begin
      state_d = state_q;
      cnt_d   = cnt_q;
      addr_d  = addr_q;
      write_d = write_q;
      wdata_d = wdata_q;
      mem_d   = mem_q;
      if (state_q == ACCESS) begin
         if (!sel) state_d = IDLE;
         else if (enable) begin
            if (cnt_q != '0) cnt_d = cnt_q - CW'(1);
            else begin
               state_d = DONE;
               if (write_q && in_range)
                  for (int i = 0; i < DATA_WIDTH/8; i++)
                     if (strobe[i]) mem_d[idx][8*i +: 8] = wdata_q[8*i +: 8];
            end
         end
      end else if (sel && !enable) begin
         // DONE decodes exactly like IDLE so back-to-back setups need no gap
         state_d = ACCESS;
         cnt_d   = CW'(WAIT_CYCLES);
         addr_d  = addr;
         write_d = write;
         wdata_d = wdata;
      end else state_d = IDLE;
   end
   always_ff @(posedge clk) begin
      if (rst) begin
         state_q <= IDLE;
         cnt_q   <= '0;
         addr_q  <= '0;
         write_q <= 1'b0;
         wdata_q <= '0;
         mem_q   <= '{default: '0};
      end else begin
         state_q <= state_d;
         cnt_q   <= cnt_d;
         addr_q  <= addr_d;
         write_q <= write_d;
         wdata_q <= wdata_d;
         mem_q   <= mem_d;
      end
   end
endmodule

// File: tb/tb_apb_slave_mem.sv
// tb_apb_slave_mem: scoreboard bench for apb_slave_mem with a 2-wait and a zero-wait instance
module tb_apb_slave_mem;
   typedef struct {
      int          d;
      bit          wr;
      logic [31:0] rd;
      bit          err;
      int          lat;
   } exp_t;
   logic        clk, rst;
   logic [1:0]  sel, enable, write, ready, slverr;
   logic [3:0]  strobe [2];
   logic [7:0]  addr [2];
   logic [31:0] wdata [2];
   logic [31:0] rdata [2];
   logic [31:0] model [2][16];
   exp_t        sb [$];
   int          acc [2];
   int          tests = 0;
   int          fails = 0;
   apb_slave_mem #(.WAIT_CYCLES(2)) u0 (
      .clk(clk), .rst(rst), .sel(sel[0]), .enable(enable[0]), .write(write[0]),
      .strobe(strobe[0]), .addr(addr[0]), .wdata(wdata[0]),
      .rdata(rdata[0]), .ready(ready[0]), .slverr(slverr[0]));
   apb_slave_mem #(.WAIT_CYCLES(0)) u1 (
      .clk(clk), .rst(rst), .sel(sel[1]), .enable(enable[1]), .write(write[1]),
      .strobe(strobe[1]), .addr(addr[1]), .wdata(wdata[1]),
      .rdata(rdata[1]), .ready(ready[1]), .slverr(slverr[1]));
   initial clk = 1'b0;
   always #5 clk = ~clk;
   task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
      tests++;
      if (act !== exp) begin
         fails++;
         $display("FAIL %s: got %h expected %h at %0t", nm, act, exp, $time);
      end
   endtask
   always @(negedge clk) begin
      for (int d = 0; d < 2; d++) begin
         if (sel[d] && !enable[d]) acc[d] = 0;
         else if (sel[d] && enable[d]) acc[d]++;
         if (rst) chk("rst_ready", 32'(ready[d]), 0);
         if (ready[d]) begin
            if (sb.size() == 0) chk("unexpected_ready", 32'(d), 32'hFFFF_FFFF);
            else begin
               exp_t e;
               e = sb.pop_front();
               chk("sb_dut", 32'(d), 32'(e.d));
               chk("latency", 32'(acc[d]), 32'(e.lat));
               chk("slverr", 32'(slverr[d]), 32'(e.err));
               if (!e.wr) chk("rdata", rdata[d], e.rd);
            end
         end else begin
            chk("idle_rdata", rdata[d], 0);
            chk("idle_slverr", 32'(slverr[d]), 0);
         end
      end
   end
   task automatic xfer(input int d, input bit wr, input logic [7:0] a, input logic [31:0] wd, input logic [3:0] st);
      exp_t e;
      int   n;
      e.d   = d;
      e.wr  = wr;
      e.err = a >= 16;
      e.lat = (d == 0 ? 2 : 0) + 1;
      e.rd  = (!wr && a < 16) ? model[d][a[3:0]] : 32'h0;
      if (wr && a < 16)
         for (int i = 0; i < 4; i++)
            if (st[i]) model[d][a[3:0]][8*i +: 8] = wd[8*i +: 8];
      sb.push_back(e);
      @(posedge clk); #1;
      sel[d] = 1'b1; enable[d] = 1'b0; write[d] = wr; addr[d] = a; wdata[d] = wd; strobe[d] = 4'($urandom);
      @(posedge clk); #1;
      enable[d] = 1'b1; strobe[d] = st;
      addr[d] = 8'($urandom); wdata[d] = $urandom; write[d] = 1'($urandom);
      n = 0;
      @(negedge clk);
      while (!ready[d] && n < 20) begin
         @(posedge clk); #1;
         addr[d] = 8'($urandom); wdata[d] = $urandom;
         @(negedge clk);
         n++;
      end
      if (!ready[d]) begin
         chk("ready_timeout", 32'(n), 0);
         if (sb.size() != 0) void'(sb.pop_back());
      end
   endtask
   task automatic idle(input int d, input int n);
      @(posedge clk); #1;
      sel[d] = 1'b0; enable[d] = 1'b0;
      repeat (n) @(negedge clk);
   endtask
   task automatic abort_wr(input int d, input logic [7:0] a, input logic [31:0] wd, input int n);
      @(posedge clk); #1;
      sel[d] = 1'b1; enable[d] = 1'b0; write[d] = 1'b1; addr[d] = a; wdata[d] = wd;
      repeat (n) begin
         @(posedge clk); #1;
         enable[d] = 1'b1; strobe[d] = 4'hF;
      end
      @(posedge clk); #1;
      sel[d] = 1'b0; enable[d] = 1'b0;
      @(negedge clk);
   endtask
   task automatic no_setup(input int d);
      @(posedge clk); #1;
      sel[d] = 1'b1; enable[d] = 1'b1; write[d] = 1'b1; addr[d] = 8'd4; wdata[d] = $urandom; strobe[d] = 4'hF;
      repeat (4) @(posedge clk);
      #1 sel[d] = 1'b0; enable[d] = 1'b0;
      @(negedge clk);
   endtask
   task automatic clear_model();
      for (int d = 0; d < 2; d++)
         for (int w = 0; w < 16; w++) model[d][w] = 32'h0;
   endtask
   initial begin
      #2_000_000;
      $display("FAIL watchdog: got timeout expected finish");
      $fatal(1, "watchdog");
   end
   initial begin
      rst = 1'b1;
      sel = '0; enable = '0; write = '0;
      for (int d = 0; d < 2; d++) begin
         strobe[d] = '0; addr[d] = '0; wdata[d] = '0; acc[d] = 0;
      end
      clear_model();
      repeat (3) @(posedge clk);
      #1 rst = 1'b0;
      for (int w = 0; w < 16; w++) xfer(0, 1'b0, 8'(w), 32'h0, 4'h0);
      xfer(0, 1'b1, 8'd3, 32'hDEADBEEF, 4'hF);
      xfer(0, 1'b0, 8'd3, 32'h0, 4'h0);
      idle(0, 2);
      xfer(0, 1'b1, 8'd5, 32'h11223344, 4'hF);
      xfer(0, 1'b1, 8'd5, 32'hAABBCCDD, 4'h5);
      xfer(0, 1'b0, 8'd5, 32'h0, 4'h0);
      xfer(0, 1'b1, 8'd7, 32'hCAFEF00D, 4'h0);
      xfer(0, 1'b0, 8'd7, 32'h0, 4'h0);
      xfer(0, 1'b0, 8'd16, 32'h0, 4'h0);
      xfer(0, 1'b1, 8'd16, 32'h5A5A5A5A, 4'hF);
      xfer(0, 1'b1, 8'hFF, 32'h12345678, 4'hF);
      for (int w = 0; w < 16; w++) xfer(0, 1'b0, 8'(w), 32'h0, 4'h0);
      xfer(1, 1'b1, 8'd0, 32'h01010101, 4'hF);
      xfer(1, 1'b1, 8'd1, 32'h02020202, 4'hF);
      xfer(1, 1'b1, 8'd2, 32'h03030303, 4'hF);
      for (int w = 0; w < 3; w++) xfer(1, 1'b0, 8'(w), 32'h0, 4'h0);
      idle(1, 1);
      xfer(0, 1'b1, 8'd2, 32'hA5A5A5A5, 4'hF);
      idle(0, 2);
      abort_wr(0, 8'd2, 32'h99999999, 1);
      xfer(0, 1'b0, 8'd2, 32'h0, 4'h0);
      xfer(0, 1'b1, 8'd9, 32'h0BADCAFE, 4'hF);
      xfer(0, 1'b0, 8'd9, 32'h0, 4'h0);
      idle(0, 1);
      no_setup(0);
      xfer(0, 1'b0, 8'd4, 32'h0, 4'h0);
      idle(0, 1);
      repeat (300) begin
         int d;
         d = int'($urandom_range(0, 1));
         if ($urandom_range(0, 3) == 0) idle(d, int'($urandom_range(1, 3)));
         xfer(d, 1'($urandom), ($urandom_range(0, 9) == 0) ? 8'($urandom) : 8'($urandom_range(0, 17)),
              $urandom, 4'($urandom));
      end
      idle(0, 1);
      idle(1, 1);
      xfer(0, 1'b1, 8'd1, 32'h77777777, 4'hF);
      @(posedge clk); #1;
      sel[0] = 1'b1; enable[0] = 1'b0; write[0] = 1'b1; addr[0] = 8'd1; wdata[0] = 32'h13579BDF;
      @(posedge clk); #1;
      enable[0] = 1'b1; strobe[0] = 4'hF;
      @(posedge clk); #1;
      rst = 1'b1;
      repeat (2) @(posedge clk);
      #1 rst = 1'b0; sel[0] = 1'b0; enable[0] = 1'b0;
      clear_model();
      @(negedge clk);
      xfer(0, 1'b0, 8'd1, 32'h0, 4'h0);
      xfer(1, 1'b0, 8'd1, 32'h0, 4'h0);
      idle(0, 1);
      idle(1, 3);
      chk("sb_empty", 32'(sb.size()), 0);
      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end
endmodule

// File: doc/apb_slave_mem.md
APB_SLAVE_MEM -- requirements
Module: apb_slave_mem

Interface
Parameters:
REQ-001 SHALL provide parameter ADDR_WIDTH, default 8: width of addr; addr is a word index.
REQ-002 SHALL provide parameter DATA_WIDTH, default 32: width of wdata and rdata.
REQ-003 SHALL provide parameter DEPTH, default 16: number of DATA_WIDTH-bit words in storage.
REQ-004 SHALL provide parameter WAIT_CYCLES, default 2: wait states inserted in ACCESS before ready (0 = zero-wait).

Ports:
REQ-005 SHALL provide port clk, input, 1: single clock; all state changes on its rising edge.
REQ-006 SHALL provide port rst, input, 1: reset, synchronous and active-high.
REQ-007 SHALL provide port sel, input, 1: APB select from the upstream master.
REQ-008 SHALL provide port enable, input, 1: APB enable; high marks the access phase.
REQ-009 SHALL provide port write, input, 1: 1 = write transfer, 0 = read transfer.
REQ-010 SHALL provide port strobe, input, DATA_WIDTH/8: byte write strobes, valid in the access phase.
REQ-011 SHALL provide port addr, input, ADDR_WIDTH: word address.
REQ-012 SHALL provide port wdata, input, DATA_WIDTH: write data.
REQ-013 SHALL provide port rdata, output, DATA_WIDTH: read data.
REQ-014 SHALL provide port ready, output, 1: transfer-complete indication.
REQ-015 SHALL provide port slverr, output, 1: error response; valid only while ready is high.

Function
REQ-016 SHALL implement a state machine with states IDLE, ACCESS and DONE, plus a wait counter of width clog2(WAIT_CYCLES+1).
REQ-017 IDLE: when sel=1 and enable=0 (setup phase), SHALL capture addr, write and wdata, load the counter with WAIT_CYCLES, and enter ACCESS.
REQ-018 IDLE: when sel=0, or sel=1 with enable=1 but no preceding setup phase, SHALL stay in IDLE with ready=0 and ignore the transfer.
REQ-019 ACCESS with sel=1, enable=1 and counter>0: SHALL decrement the counter and hold ready=0.
REQ-020 ACCESS with sel=1, enable=1 and counter=0: SHALL drive ready=1 combinationally in that cycle and enter DONE at the next edge.
REQ-021 ACCESS with sel=0: SHALL abort to IDLE with no storage write.
REQ-022 DONE: SHALL behave exactly as IDLE (same setup capture and decoding), so back-to-back setup phases are accepted with no idle gap.
REQ-023 Latency: ready SHALL rise in the (WAIT_CYCLES+1)-th access-phase cycle after the setup cycle.
REQ-024 Write in range (captured addr < DEPTH): on the edge where ready=1, byte lane i of mem[addr] SHALL be updated from wdata only where strobe[i]=1; all other lanes SHALL be unchanged.
REQ-025 Write with strobe=0: SHALL complete with ready=1 and slverr=0, and SHALL modify no bytes.
REQ-026 Read in range: while ready=1, rdata SHALL equal mem[captured addr], with no bytes masked.
REQ-027 Out-of-range access (addr >= DEPTH): SHALL drive slverr=1 with ready, suppress the write, and drive rdata=0.
REQ-028 Outside the ready cycle: rdata SHALL be 0 and slverr SHALL be 0.
REQ-029 A write and a read of the same word in consecutive transfers SHALL return the newly written data.
REQ-030 Changes to addr, write or wdata during the access phase SHALL be ignored; the values captured at setup apply.

Reset
REQ-031 While rst=1 at a clock edge: state SHALL go to IDLE, counter to 0, and captured registers to 0.
REQ-032 While rst=1: ready, slverr and rdata SHALL be 0.
REQ-033 Storage contents SHALL be cleared to 0 on reset.
REQ-034 Reset asserted mid-transfer SHALL abort the transfer with no storage write; the first transfer after rst deasserts SHALL begin with a fresh setup phase.

Verification
REQ-035 Write then read, WAIT_CYCLES=2: write addr=3, wdata=0xDEADBEEF, strobe=0xF, then read addr=3 -> ready high on the 3rd access cycle of each transfer, rdata=0xDEADBEEF, slverr=0.
REQ-036 Byte strobes: after mem[5]=0x11223344, write addr=5, wdata=0xAABBCCDD, strobe=0x5; then read -> rdata=0x11BB33DD.
REQ-037 Error response: read addr=16 (DEPTH=16) -> ready=1, slverr=1, rdata=0; a write to addr=16 leaves every word unchanged.
REQ-038 Zero-wait back-to-back, WAIT_CYCLES=0: three consecutive writes with no IDLE between them -> ready high in every access cycle and all three words updated.
REQ-039 Abort: sel drops during the 1st wait cycle of a write to addr=2 -> mem[2] unchanged, ready never high, and the next transfer completes normally.
REQ-040 Reset mid-access: assert rst during the wait of a write to addr=1 -> mem[1]=0 and ready=0; a following read of addr=1 returns 0.
